instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_if.sv | 32 +++
 rtl/instr_encoder.sv | 197 +++++++++++++++++++
 tb/tb_instr_encoder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder.
// The encoder side uses the slave modport; the producer/consumer side uses master.
interface instr_encoder_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [2:0]  fmt_i;
    logic [6:0]  opcode_i;
    logic [4:0]  rd_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] imm_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] instr_o;
    logic        err_o;
    logic [1:0]  err_code_o;
    logic [15:0] count_o;

    modport slave (
        input  in_valid_i, fmt_i, opcode_i, rd_i, rs1_i, rs2_i,
               funct3_i, funct7_i, imm_i, out_ready_i,
        output in_ready_o, out_valid_o, instr_o, err_o, err_code_o, count_o
    );

    modport master (
        output in_valid_i, fmt_i, opcode_i, rd_i, rs1_i, rs2_i,
               funct3_i, funct7_i, imm_i, out_ready_i,
        input  in_ready_o, out_valid_o, instr_o, err_o, err_code_o, count_o
    );
endinterface

// File: rtl/instr_encoder.sv
// Two-stage RV32I instruction encoder: S1 holds request fields and feeds the
// format/range checks, S2 holds the encoded word and error status for the consumer.
module instr_encoder (
    input  logic           clk_i,
    input  logic           rst_i,
    instr_encoder_if.slave bus
);
    typedef enum logic [2:0] {
        FMT_I     = 3'd0,
        FMT_SHIFT = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5
    } fmt_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_RANGE    = 2'd1,
        ERR_MISALIGN = 2'd2,
        ERR_ILLEGAL  = 2'd3
    } err_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic        s1_valid_q,  s1_valid_d;
    logic [2:0]  s1_fmt_q,    s1_fmt_d;
    logic [6:0]  s1_opcode_q, s1_opcode_d;
    logic [4:0]  s1_rd_q,     s1_rd_d;
    logic [4:0]  s1_rs1_q,    s1_rs1_d;
    logic [4:0]  s1_rs2_q,    s1_rs2_d;
    logic [2:0]  s1_funct3_q, s1_funct3_d;
    logic [6:0]  s1_funct7_q, s1_funct7_d;
    logic [31:0] s1_imm_q,    s1_imm_d;

    logic        out_valid_q, out_valid_d;
    logic [31:0] instr_q,     instr_d;
    logic        err_q,       err_d;
    logic [1:0]  err_code_q,  err_code_d;
    logic [15:0] count_q,     count_d;

    logic        s2_adv;
    logic        in_ready;
    logic        fits_12;
    logic        fits_13;
    logic        fits_21;
    logic        range_err;
    logic        misaligned;
    logic        legal;
    logic [31:0] enc_word;
    logic [1:0]  enc_err;

    // Signed-range tests reduce to "all bits above the field are a sign copy".
    assign fits_12 = (&s1_imm_q[31:11]) | ~(|s1_imm_q[31:11]);
    assign fits_13 = (&s1_imm_q[31:12]) | ~(|s1_imm_q[31:12]);
    assign fits_21 = (&s1_imm_q[31:20]) | ~(|s1_imm_q[31:20]);

    always_comb begin
        enc_word   = '0;
        range_err  = 1'b0;
        misaligned = 1'b0;
        legal      = 1'b1;
        case (s1_fmt_q)
            FMT_I: begin
                enc_word  = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
                range_err = !fits_12;
            end
            FMT_SHIFT: begin
                enc_word  = {s1_funct7_q, s1_imm_q[4:0], s1_rs1_q, s1_funct3_q, s1_rd_q,
                             s1_opcode_q};
                range_err = |s1_imm_q[31:5];
            end
            FMT_S: begin
                enc_word  = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_imm_q[4:0],
                             s1_opcode_q};
                range_err = !fits_12;
            end
            FMT_B: begin
                enc_word   = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                              s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
                range_err  = !fits_13;
                misaligned = s1_imm_q[0];
            end
            FMT_U: begin
                enc_word  = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
                range_err = |s1_imm_q[11:0];
            end
            FMT_J: begin
                enc_word   = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                              s1_rd_q, s1_opcode_q};
                range_err  = !fits_21;
                misaligned = s1_imm_q[0];
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            enc_err = ERR_ILLEGAL;
        end else if (misaligned) begin
            enc_err = ERR_MISALIGN;
        end else if (range_err) begin
            enc_err = ERR_RANGE;
        end else begin
            enc_err = ERR_NONE;
        end
    end

    always_comb begin
        s2_adv   = !out_valid_q || bus.out_ready_i;
        in_ready = !s1_valid_q || s2_adv;

        s1_valid_d  = s1_valid_q;
        s1_fmt_d    = s1_fmt_q;
        s1_opcode_d = s1_opcode_q;
        s1_rd_d     = s1_rd_q;
        s1_rs1_d    = s1_rs1_q;
        s1_rs2_d    = s1_rs2_q;
        s1_funct3_d = s1_funct3_q;
        s1_funct7_d = s1_funct7_q;
        s1_imm_d    = s1_imm_q;
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        count_d     = count_q;

        if (in_ready) begin
            s1_valid_d = bus.in_valid_i;
            if (bus.in_valid_i) begin
                s1_fmt_d    = bus.fmt_i;
                s1_opcode_d = bus.opcode_i;
                s1_rd_d     = bus.rd_i;
                s1_rs1_d    = bus.rs1_i;
                s1_rs2_d    = bus.rs2_i;
                s1_funct3_d = bus.funct3_i;
                s1_funct7_d = bus.funct7_i;
                s1_imm_d    = bus.imm_i;
            end
        end

        // Output registers only load on a real S1->S2 move, so they keep the
        // last delivered word while the pipeline is empty.
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                err_d      = (enc_err != ERR_NONE);
                err_code_d = enc_err;
                instr_d    = (enc_err != ERR_NONE) ? NOP_WORD : enc_word;
            end
        end

        if (out_valid_q && bus.out_ready_i && !err_q && (count_q != '1)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_fmt_q    <= '0;
            s1_opcode_q <= '0;
            s1_rd_q     <= '0;
            s1_rs1_q    <= '0;
            s1_rs2_q    <= '0;
            s1_funct3_q <= '0;
            s1_funct7_q <= '0;
            s1_imm_q    <= '0;
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            count_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_fmt_q    <= s1_fmt_d;
            s1_opcode_q <= s1_opcode_d;
            s1_rd_q     <= s1_rd_d;
            s1_rs1_q    <= s1_rs1_d;
            s1_rs2_q    <= s1_rs2_d;
            s1_funct3_q <= s1_funct3_d;
            s1_funct7_q <= s1_funct7_d;
            s1_imm_q    <= s1_imm_d;
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            count_q     <= count_d;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid_q;
    assign bus.instr_o     = instr_q;
    assign bus.err_o       = err_q;
    assign bus.err_code_o  = err_code_q;
    assign bus.count_o     = count_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus random traffic, scored
// against an arithmetic model of the RV32I encoding and range rules.
module tb_instr_encoder;
    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [1:0]  code;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_mis;
    int   mcount;
    logic last_acc;
    logic prev_stall;
    logic [35:0] prev_out;
    exp_t q[$];
    int   bnd[18] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                      -1048577, -1048576, 1048574, 1048575, 1048576, 31, 32, 0, -1};

    instr_encoder_if bus ();

    instr_encoder dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint unsigned fld(longint unsigned x, int hi, int lo);
        return (x >> lo) % (64'd1 << (hi - lo + 1));
    endfunction

    function automatic exp_t ref_model(logic [2:0] fmt, logic [6:0] op, logic [4:0] rd,
                                       logic [4:0] rs1, logic [4:0] rs2, logic [2:0] f3,
                                       logic [6:0] f7, logic [31:0] imm);
        exp_t e;
        longint s;
        longint unsigned u;
        longint unsigned w;
        longint unsigned base;
        int code;
        s    = longint'($signed(imm));
        u    = {32'd0, imm};
        code = 0;
        w    = 0;
        base = longint'(op) + (longint'(f3) << 12) + (longint'(rs1) << 15);
        if (fmt > 3'd5) code = 3;
        else if ((fmt == 3'd3 || fmt == 3'd5) && (u % 2 == 1)) code = 2;
        else begin
            case (fmt)
                3'd0, 3'd2: if (s < -2048 || s > 2047) code = 1;
                3'd1:       if (u > 31) code = 1;
                3'd3:       if (s < -4096 || s > 4094) code = 1;
                3'd4:       if (u % 4096 != 0) code = 1;
                default:    if (s < -1048576 || s > 1048574) code = 1;
            endcase
        end
        case (fmt)
            3'd0: w = base + (longint'(rd) << 7) + (fld(u, 11, 0) << 20);
            3'd1: w = base + (longint'(rd) << 7) + (fld(u, 4, 0) << 20) + (longint'(f7) << 25);
            3'd2: w = base + (fld(u, 4, 0) << 7) + (longint'(rs2) << 20) + (fld(u, 11, 5) << 25);
            3'd3: w = base + (fld(u, 11, 11) << 7) + (fld(u, 4, 1) << 8) + (longint'(rs2) << 20)
                      + (fld(u, 10, 5) << 25) + (fld(u, 12, 12) << 31);
            3'd4: w = longint'(op) + (longint'(rd) << 7) + (fld(u, 31, 12) << 12);
            3'd5: w = longint'(op) + (longint'(rd) << 7) + (fld(u, 19, 12) << 12)
                      + (fld(u, 11, 11) << 20) + (fld(u, 10, 1) << 21) + (fld(u, 20, 20) << 31);
            default: w = 0;
        endcase
        e.err   = (code != 0);
        e.code  = 2'(code);
        e.instr = (code != 0) ? 32'h0000_0013 : w[31:0];
        return e;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic r, del, acc, stall;
        logic [35:0] cur;
        exp_t e;
        @(negedge clk);
        r     = rst;
        acc   = bus.in_valid_i && bus.in_ready_o;
        del   = bus.out_valid_o && bus.out_ready_i;
        stall = bus.out_valid_o && !bus.out_ready_i;
        cur   = {bus.out_valid_o, bus.instr_o, bus.err_o, bus.err_code_o};
        last_acc = 1'b0;
        if (r) begin
            q.delete();
            mcount     = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("hold_outputs", 64'(cur), 64'(prev_out));
            prev_stall = stall;
            prev_out   = cur;
            if (del) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 64'(bus.out_valid_o), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("instr", 64'(bus.instr_o), 64'(e.instr));
                    chk("err", 64'(bus.err_o), 64'(e.err));
                    chk("err_code", 64'(bus.err_code_o), 64'(e.code));
                    if (!e.err && mcount < 65535) mcount++;
                end
            end
            if (acc) begin
                q.push_back(ref_model(bus.fmt_i, bus.opcode_i, bus.rd_i, bus.rs1_i, bus.rs2_i,
                                      bus.funct3_i, bus.funct7_i, bus.imm_i));
                last_acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("count", 64'(bus.count_o), 64'(mcount));
    endtask

    task automatic set_req(int fmt, int op, int rd, int rs1, int rs2, int f3, int f7,
                           logic [31:0] imm);
        bus.fmt_i    = 3'(fmt);
        bus.opcode_i = 7'(op);
        bus.rd_i     = 5'(rd);
        bus.rs1_i    = 5'(rs1);
        bus.rs2_i    = 5'(rs2);
        bus.funct3_i = 3'(f3);
        bus.funct7_i = 7'(f7);
        bus.imm_i    = imm;
    endtask

    task automatic send();
        bus.in_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (last_acc) break;
        end
        chk("accept_timeout", 64'(last_acc), 64'd1);
        bus.in_valid_i = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) tick();
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic one_shot(logic [31:0] exp_instr, logic [1:0] exp_code);
        bus.out_ready_i = 1'b1;
        bus.in_valid_i  = 1'b1;
        tick();
        bus.in_valid_i  = 1'b0;
        chk("lat1_out_valid", 64'(bus.out_valid_o), 64'd0);
        tick();
        chk("lat2_out_valid", 64'(bus.out_valid_o), 64'd1);
        chk("lat2_instr", 64'(bus.instr_o), 64'(exp_instr));
        chk("lat2_err_code", 64'(bus.err_code_o), 64'(exp_code));
        chk("lat2_err", 64'(bus.err_o), 64'(exp_code != 2'd0));
    endtask

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 5))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 4095)) - 32'd2048;
            2:       return 32'(bnd[$urandom_range(0, 17)]);
            3:       return $urandom & 32'hFFFF_F000;
            4:       return 32'($urandom_range(0, 63));
            default: return 32'($urandom_range(0, 2097151)) - 32'd1048576;
        endcase
    endfunction

    initial begin
        n_cmp = 0; n_mis = 0; mcount = 0;
        last_acc = 1'b0; prev_stall = 1'b0; prev_out = '0;
        rst = 1'b1;
        bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0;
        set_req(0, 0, 0, 0, 0, 0, 0, 32'd0);
        tick(); tick();
        rst = 1'b0;
        chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_instr", 64'(bus.instr_o), 64'd0);
        chk("rst_err", 64'(bus.err_o), 64'd0);
        chk("rst_err_code", 64'(bus.err_code_o), 64'd0);
        chk("rst_count", 64'(bus.count_o), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready_o), 64'd1);

        set_req(0, 7'h13, 1, 2, 0, 0, 0, 32'hFFFF_FFFF);
        one_shot(32'hFFF1_0093, 2'd0);
        set_req(3, 7'h63, 0, 1, 2, 0, 0, 32'd8);
        one_shot(32'h0020_8463, 2'd0);
        set_req(3, 7'h63, 0, 1, 2, 0, 0, 32'd7);
        one_shot(32'h0000_0013, 2'd2);
        set_req(4, 7'h37, 5, 0, 0, 0, 0, 32'h1234_5000);
        one_shot(32'h1234_52B7, 2'd0);
        set_req(5, 7'h6F, 1, 0, 0, 0, 0, 32'h0010_0000);
        one_shot(32'h0000_0013, 2'd1);
        set_req(6, 7'h13, 3, 4, 5, 1, 0, 32'd0);
        one_shot(32'h0000_0013, 2'd3);

        // Back-to-back under a 3-cycle consumer stall, starting from zero count.
        rst = 1'b1; tick(); rst = 1'b0;
        bus.out_ready_i = 1'b0;
        set_req(0, 7'h13, 1, 1, 0, 0, 0, 32'd1);  send();
        set_req(2, 7'h23, 0, 2, 3, 2, 0, 32'd16); send();
        chk("bp_in_ready_low", 64'(bus.in_ready_o), 64'd0);
        set_req(4, 7'h17, 4, 0, 0, 0, 0, 32'hABCD_E000);
        bus.in_valid_i = 1'b1;
        tick();
        chk("bp_stalled_accept", 64'(last_acc), 64'd0);
        bus.out_ready_i = 1'b1;
        send();
        set_req(5, 7'h6F, 6, 0, 0, 0, 0, 32'hFFFF_FFF0); send();
        drain();
        chk("bp_count4", 64'(bus.count_o), 64'd4);

        // Reset with two requests in flight; nothing may emerge afterwards.
        bus.out_ready_i = 1'b0;
        set_req(0, 7'h13, 7, 8, 0, 0, 0, 32'd5); send();
        set_req(0, 7'h13, 9, 8, 0, 0, 0, 32'd6); send();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_out_valid", 64'(bus.out_valid_o), 64'd0);
        chk("midrst_count", 64'(bus.count_o), 64'd0);
        bus.out_ready_i = 1'b1;
        repeat (6) tick();

        for (int i = 0; i < 500; i++) begin
            set_req($urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 31),
                    $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 7),
                    $urandom_range(0, 127), rand_imm());
            bus.in_valid_i  = ($urandom_range(0, 3) != 0);
            bus.out_ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        set_req(0, 7'h13, 1, 0, 0, 0, 0, 32'd0);
        bus.in_valid_i  = 1'b1;
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 70000 && mcount < 65535; i++) tick();
        repeat (6) tick();
        chk("count_saturated", 64'(bus.count_o), 64'hFFFF);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
